ex_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 19 +
 rtl/alu_core.sv | 51 +++++
 rtl/ex_stage.sv | 104 ++++++++++
 tb/tb_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline widths, alu_ctrl encoding and forward-select codes
package pipeline_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_AW = 5;

  // Must stay bit-identical to the ALU control decoder's output encoding
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU; signed overflow reported only when ALU_OVF_TRAP_EN is defined
module alu_core
  import pipeline_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              slt;

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVF_TRAP_EN
  always_comb begin
    ovf = 1'b0;
    case (alu_ctrl)
      ALU_ADD: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      ALU_SUB: ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forward muxes, ALU and EX/MEM register with stall/flush
// Optional overflow trap via ALU_OVF_TRAP_EN (handled inside alu_core).
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic              alu_src,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] exmem_fwd_data,
  input  logic [DATA_W-1:0] memwb_fwd_data,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  output logic              exmem_valid,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic              exmem_zero,
  output logic [DATA_W-1:0] exmem_store_data,
  output logic [REG_AW-1:0] exmem_rd,
  output logic              exmem_reg_write,
  output logic              exmem_mem_read,
  output logic              exmem_mem_write,
  output logic              exmem_mem_to_reg,
  output logic              exmem_ovf
);

  logic [DATA_W-1:0] fwd_a_data;
  logic [DATA_W-1:0] fwd_b_data;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_ovf;

  // Code 11 is not a legal forward request; it falls back to register-file data
  always_comb begin
    fwd_a_data = rs_data;
    case (fwd_a)
      FWD_EXMEM: fwd_a_data = exmem_fwd_data;
      FWD_MEMWB: fwd_a_data = memwb_fwd_data;
      default:   fwd_a_data = rs_data;
    endcase
  end

  always_comb begin
    fwd_b_data = rt_data;
    case (fwd_b)
      FWD_EXMEM: fwd_b_data = exmem_fwd_data;
      FWD_MEMWB: fwd_b_data = memwb_fwd_data;
      default:   fwd_b_data = rt_data;
    endcase
  end

  assign alu_b = alu_src ? imm_ext : fwd_b_data;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a        (fwd_a_data),
    .b        (alu_b),
    .alu_ctrl (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero),
    .ovf      (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      exmem_valid      <= 1'b0;
      exmem_alu_result <= '0;
      exmem_zero       <= 1'b0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_reg_write  <= 1'b0;
      exmem_mem_read   <= 1'b0;
      exmem_mem_write  <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_ovf        <= 1'b0;
    end else if (!stall) begin
      exmem_valid      <= in_valid;
      exmem_alu_result <= alu_result;
      exmem_zero       <= alu_zero;
      exmem_store_data <= fwd_b_data;
      exmem_rd         <= rd_in;
      // A trapped instruction must not commit its wrapped result
      exmem_reg_write  <= reg_write_in & in_valid & ~alu_ovf;
      exmem_mem_read   <= mem_read_in & in_valid;
      exmem_mem_write  <= mem_write_in & in_valid;
      exmem_mem_to_reg <= mem_to_reg_in & in_valid;
      exmem_ovf        <= alu_ovf & in_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage against a behavioural next-state model
module tb_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic        zero;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        ovf;
  } exo_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, alu_src;
  logic [3:0]  alu_ctrl;
  logic [31:0] rs_data, rt_data, imm_ext, exmem_fwd_data, memwb_fwd_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        exmem_valid, exmem_zero, exmem_reg_write, exmem_mem_read;
  logic        exmem_mem_write, exmem_mem_to_reg, exmem_ovf;
  logic [31:0] exmem_alu_result, exmem_store_data;
  logic [4:0]  exmem_rd;

  int   errors = 0;
  int   checks = 0;
  exo_t exp_q;
  exo_t obs;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_ctrl(alu_ctrl), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .exmem_valid(exmem_valid), .exmem_alu_result(exmem_alu_result),
    .exmem_zero(exmem_zero), .exmem_store_data(exmem_store_data),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .exmem_mem_to_reg(exmem_mem_to_reg), .exmem_ovf(exmem_ovf)
  );

  assign obs = {exmem_valid, exmem_alu_result, exmem_zero, exmem_store_data, exmem_rd,
                exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg, exmem_ovf};

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd2) return exmem_fwd_data;
    if (sel == 2'd1) return memwb_fwd_data;
    return rf;
  endfunction

  // Expected EX/MEM contents after the next edge, from the current inputs
  function automatic exo_t model(input exo_t cur);
    exo_t        n;
    logic [31:0] a, fb, b, r;
    longint      sa, sb, full;
    logic        ov;
    if (flush) return '0;
    if (stall) return cur;
    a  = pick(fwd_a, rs_data);
    fb = pick(fwd_b, rt_data);
    b  = alu_src ? imm_ext : fb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    case (alu_ctrl)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin full = sa + sb; r = full[31:0]; ov = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      4'd6:  begin full = sa - sb; r = full[31:0]; ov = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: r = 32'd0;
    endcase
`ifndef ALU_OVF_TRAP_EN
    ov = 1'b0;
`endif
    n.valid = in_valid;
    n.res   = r;
    n.zero  = (r == 32'd0);
    n.st    = fb;
    n.rd    = rd_in;
    n.rw    = reg_write_in && in_valid && !(ov && in_valid);
    n.mr    = mem_read_in && in_valid;
    n.mw    = mem_write_in && in_valid;
    n.m2r   = mem_to_reg_in && in_valid;
    n.ovf   = ov && in_valid;
    return n;
  endfunction

  task automatic cycle();
    exo_t nxt;
    nxt = model(exp_q);
    @(posedge clk);
    #1;
    exp_q = nxt;
  endtask

  task automatic rand_inputs();
    logic [3:0] ops [8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15, 4'd3};
    alu_ctrl       = ops[$urandom_range(7)];
    rs_data        = $urandom;
    rt_data        = ($urandom_range(7) == 0) ? rs_data : $urandom;
    imm_ext        = $urandom;
    exmem_fwd_data = $urandom;
    memwb_fwd_data = $urandom;
    alu_src        = $urandom_range(1);
    fwd_a          = $urandom_range(3);
    fwd_b          = $urandom_range(3);
    rd_in          = $urandom_range(31);
    in_valid       = ($urandom_range(3) != 0);
    reg_write_in   = $urandom_range(1);
    mem_read_in    = $urandom_range(1);
    mem_write_in   = $urandom_range(1);
    mem_to_reg_in  = $urandom_range(1);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = op; rs_data = a; rt_data = b;
    fwd_a = 2'd0; fwd_b = 2'd0; alu_src = 1'b0; in_valid = 1'b1;
    stall = 1'b0; flush = 1'b0;
    reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    exp_q = '0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk); #1;
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", obs); end
    end
    rst_n = 1'b1;
    set_op(4'd2, 32'd5, 32'd7); rd_in = 5'd3;
    cycle();
    checks++;
    if (obs !== exp_q) begin errors++; $display("FAIL reset_first_add: got %h want %h", obs, exp_q); end
    checks++;
    if ({exmem_alu_result, exmem_zero, exmem_valid, exmem_reg_write} !== {32'd12, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL reset_add_fields: got %0d/%b/%b/%b want 12/0/1/1",
                         exmem_alu_result, exmem_zero, exmem_valid, exmem_reg_write);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  op  [6];
    logic [31:0] av  [6];
    logic [31:0] bv  [6];
    logic [31:0] want[6];
    op   = '{4'd0, 4'd1, 4'd12, 4'd6, 4'd7, 4'd15};
    av   = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd3, 32'hFFFFFFFF, 32'hF0F0F0F0};
    bv   = '{32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'd3, 32'd1, 32'h0FF0FF00};
    want = '{32'h00F0F000, 32'hFFF0FFF0, 32'h000F000F, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      set_op(op[i], av[i], bv[i]);
      cycle();
      checks++;
      if (exmem_alu_result !== want[i] || exmem_zero !== (want[i] == 32'd0)) begin
        errors++; $display("FAIL ops_%0d: got %h z=%b want %h z=%b", op[i], exmem_alu_result,
                           exmem_zero, want[i], want[i] == 32'd0);
      end
      checks++;
      if (obs !== exp_q) begin errors++; $display("FAIL ops_model_%0d: got %h want %h", op[i], obs, exp_q); end
    end
  endtask

  task automatic test_forwarding();
    set_op(4'd2, 32'd1, 32'd9);
    exmem_fwd_data = 32'd100; memwb_fwd_data = 32'd50; imm_ext = 32'd4;
    fwd_a = 2'b10; fwd_b = 2'b01;
    cycle();
    checks++;
    if ({exmem_alu_result, exmem_store_data} !== {32'd150, 32'd50}) begin
      errors++; $display("FAIL fwd_reg: got %0d/%0d want 150/50", exmem_alu_result, exmem_store_data);
    end
    alu_src = 1'b1;
    cycle();
    checks++;
    if ({exmem_alu_result, exmem_store_data} !== {32'd104, 32'd50}) begin
      errors++; $display("FAIL fwd_imm: got %0d/%0d want 104/50", exmem_alu_result, exmem_store_data);
    end
    alu_src = 1'b0; fwd_a = 2'b11; fwd_b = 2'b11;
    cycle();
    checks++;
    if ({exmem_alu_result, exmem_store_data} !== {32'd10, 32'd9}) begin
      errors++; $display("FAIL fwd_11: got %0d/%0d want 10/9", exmem_alu_result, exmem_store_data);
    end
  endtask

  task automatic test_stall_flush();
    set_op(4'd2, 32'd5, 32'd7);
    mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs_data = $urandom; rt_data = $urandom; alu_ctrl = 4'd1; rd_in = $urandom_range(31);
      cycle();
      checks++;
      if (exmem_alu_result !== 32'd12 || obs !== exp_q) begin
        errors++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_q);
      end
    end
    flush = 1'b1;
    cycle();
    checks++;
    if ({exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg, exmem_ovf} !== 6'b0) begin
      errors++; $display("FAIL stall_flush: got %h want control 0", obs);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_bubble();
    set_op(4'd2, 32'd20, 32'd22);
    in_valid = 1'b0; mem_write_in = 1'b1;
    cycle();
    checks++;
    if ({exmem_valid, exmem_reg_write, exmem_mem_write, exmem_alu_result} !== {3'b000, 32'd42}) begin
      errors++; $display("FAIL bubble: got v=%b rw=%b mw=%b r=%0d want 0/0/0/42",
                         exmem_valid, exmem_reg_write, exmem_mem_write, exmem_alu_result);
    end
  endtask

  task automatic test_overflow();
    logic want_ovf;
`ifdef ALU_OVF_TRAP_EN
    want_ovf = 1'b1;
`else
    want_ovf = 1'b0;
`endif
    set_op(4'd2, 32'h7FFFFFFF, 32'd1);
    cycle();
    checks++;
    if ({exmem_alu_result, exmem_ovf, exmem_reg_write} !== {32'h80000000, want_ovf, ~want_ovf}) begin
      errors++; $display("FAIL ovf_add: got %h ovf=%b rw=%b want 80000000 ovf=%b rw=%b",
                         exmem_alu_result, exmem_ovf, exmem_reg_write, want_ovf, ~want_ovf);
    end
    set_op(4'd6, 32'h80000000, 32'd1);
    cycle();
    checks++;
    if ({exmem_alu_result, exmem_ovf, exmem_reg_write} !== {32'h7FFFFFFF, want_ovf, ~want_ovf}) begin
      errors++; $display("FAIL ovf_sub: got %h ovf=%b rw=%b want 7fffffff ovf=%b rw=%b",
                         exmem_alu_result, exmem_ovf, exmem_reg_write, want_ovf, ~want_ovf);
    end
  endtask

  task automatic test_async_reset();
    set_op(4'd1, 32'h5, 32'hA);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    exp_q = '0;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    set_op(4'd6, 32'd9, 32'd4);
    cycle();
    checks++;
    if (obs !== exp_q || exmem_alu_result !== 32'd5) begin
      errors++; $display("FAIL async_release: got %h want %h", obs, exp_q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      if ($urandom_range(9) == 0) begin
        rs_data = 32'h7FFFFFF0 + $urandom_range(31);
        rt_data = $urandom_range(31);
      end
      cycle();
      checks++;
      if (obs !== exp_q) begin errors++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_forwarding();
    test_stall_flush();
    test_bubble();
    test_overflow();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
